// File: rtl/lsu_mem_port_if.sv
// Core request/response and data-memory bus bundle for lsu_mem_port.
// slave: the load/store unit's view. master: the core + memory environment's view.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit in front of a 512-byte word-wide data memory.
// Sub-word stores are done as read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses into errors; otherwise the low address bits are cleared.
module lsu_mem_port (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] wdata_q, wdata_d;      // only the low half is needed for SB/SH merges
  logic [31:0] wr_word_q, wr_word_d;  // word presented on mem_wdata during WRITE
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        legal_f3, in_range, misaligned, illegal;
  logic [8:0]  req_addr_al;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;
  logic [31:0] merge_word;

  // Decode legality and aligned address of the request presented in IDLE
  always_comb begin
    if (bus.req_store) begin
      legal_f3 = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010);
    end else begin
      legal_f3 = (bus.req_funct3 != 3'b011) && (bus.req_funct3 != 3'b110) &&
                 (bus.req_funct3 != 3'b111);
    end
    in_range   = (bus.req_addr[31:9] == 23'd0);
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_addr_al = bus.req_addr[8:0];
`ifdef LSU_MISALIGN_TRAP_EN
    illegal = !legal_f3 || !in_range || misaligned;
`else
    illegal = !legal_f3 || !in_range;
    if (misaligned) begin
      req_addr_al[1:0] = (bus.req_funct3[1:0] == 2'b10) ? 2'b00 : {bus.req_addr[1], 1'b0};
    end
`endif
  end

  // Extract and extend the addressed lane of the memory word for loads
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   ld_byte = bus.mem_rdata[7:0];
      2'b01:   ld_byte = bus.mem_rdata[15:8];
      2'b10:   ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_result = {24'd0, ld_byte};
      3'b101:  ld_result = {16'd0, ld_half};
      default: ld_result = bus.mem_rdata;
    endcase
  end

  // Replace only the addressed byte/halfword lanes of the word read during RMW_RD
  always_comb begin
    merge_word = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      unique case (addr_q[1:0])
        2'b00:   merge_word[7:0]   = wdata_q[7:0];
        2'b01:   merge_word[15:8]  = wdata_q[7:0];
        2'b10:   merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q;
    end else begin
      merge_word[15:0] = wdata_q;
    end
  end

  // Next-state logic; response fields only change on entry to RESP so they hold in between
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    wr_word_d    = wr_word_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d   = req_addr_al;
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata[15:0];
          if (illegal) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
            state_d      = StResp;
          end else if (!bus.req_store) begin
            state_d = StLoad;
          end else if (bus.req_funct3[1:0] == 2'b10) begin
            wr_word_d = bus.req_wdata;
            state_d   = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        resp_rdata_d = ld_result;
        resp_err_d   = 1'b0;
        state_d      = StResp;
      end
      StRmwRd: begin
        wr_word_d = merge_word;
        state_d   = StWrite;
      end
      StWrite: begin
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        state_d      = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and captured-request registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= 9'd0;
      funct3_q     <= 3'd0;
      wdata_q      <= 16'd0;
      wr_word_q    <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      wr_word_q    <= wr_word_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Outputs decoded from registered state only, so strobes drop as soon as reset asserts
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.MemRead    = (state_q == StLoad) || (state_q == StRmwRd);
    bus.MemWrite   = (state_q == StWrite);
    bus.resp_valid = (state_q == StResp);
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
    bus.mem_addr   = {addr_q[8:2], 2'b00};
    bus.mem_wdata  = wr_word_q;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: word-wide memory model plus an expected-response queue.
module tb_lsu_mem_port;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hold_ok;
  } obs_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb_q[$];

  logic [31:0] mem [128];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_val;
  int          wr_cnt;
  int          both_cnt;

  lsu_mem_port_if bus ();

  lsu_mem_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (bus.MemWrite) begin
      mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.MemRead && bus.MemWrite) both_cnt <= both_cnt + 1;
  end

  task automatic preload(input logic [8:0] addr, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = addr[8:2];
    pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drive one request, scramble inputs after acceptance, observe until resp_valid (bounded)
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output obs_t o);
    int n;
    @(negedge clk);
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    o.rdata = 32'hxxxxxxxx;
    o.err = 1'bx;
    o.lat = 99;
    o.nrd = 0;
    o.nwr = 0;
    o.wr_addr = 9'd0;
    o.wr_data = 32'd0;
    o.hold_ok = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.MemRead) o.nrd++;
      if (bus.MemWrite) begin
        o.nwr++;
        o.wr_addr = bus.mem_addr;
        o.wr_data = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        o.lat   = c;
        o.rdata = bus.resp_rdata;
        o.err   = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    o.hold_ok = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1) &&
                (bus.resp_rdata === o.rdata) && (bus.resp_err === o.err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.MemRead, bus.MemWrite, bus.resp_valid, bus.resp_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=0000",
               {bus.MemRead, bus.MemWrite, bus.resp_valid, bus.resp_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.resp_rdata} !== 73'd0) begin
      bad++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h want=0", bus.mem_addr,
               bus.mem_wdata, bus.resp_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_sw_lw();
    obs_t o;
    exp_t e;
    sb_q.push_back('{32'd0, 1'b0, 2, 0, 1});
    run_req(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, o);
    e = sb_q.pop_front();
    total++;
    if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd ||
        o.nwr != e.nwr || !o.hold_ok) begin
      bad++;
      $display("FAIL sw rdata=%h err=%b lat=%0d rd=%0d wr=%0d hold=%b want %h %b %0d %0d %0d 1",
               o.rdata, o.err, o.lat, o.nrd, o.nwr, o.hold_ok, e.rdata, e.err, e.lat, e.nrd,
               e.nwr);
    end
    total++;
    if (o.wr_addr !== 9'h010 || o.wr_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL sw_bus addr=%h data=%h want 010 deadbeef", o.wr_addr, o.wr_data);
    end
    sb_q.push_back('{32'hDEADBEEF, 1'b0, 2, 1, 0});
    run_req(1'b0, 3'b010, 32'h010, 32'h0, o);
    e = sb_q.pop_front();
    total++;
    if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd ||
        o.nwr != e.nwr || !o.hold_ok) begin
      bad++;
      $display("FAIL lw rdata=%h err=%b lat=%0d rd=%0d wr=%0d hold=%b want %h %b %0d %0d %0d 1",
               o.rdata, o.err, o.lat, o.nrd, o.nwr, o.hold_ok, e.rdata, e.err, e.lat, e.nrd,
               e.nwr);
    end
  endtask

  task automatic test_rmw();
    obs_t o;
    exp_t e;
    logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b000};
    logic [31:0] ad  [3] = '{32'h023, 32'h022, 32'h021};
    logic [31:0] wd  [3] = '{32'h000000AA, 32'hBEEF5566, 32'hFFFFFF77};
    logic [31:0] img [3] = '{32'hAA223344, 32'h55663344, 32'h55667744};
    preload(9'h020, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{32'd0, 1'b0, 3, 1, 1});
      run_req(1'b1, f3[i], ad[i], wd[i], o);
      e = sb_q.pop_front();
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd ||
          o.nwr != e.nwr || !o.hold_ok) begin
        bad++;
        $display("FAIL rmw%0d rdata=%h err=%b lat=%0d rd=%0d wr=%0d hold=%b want %h %b %0d %0d %0d 1",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, o.hold_ok, e.rdata, e.err, e.lat,
                 e.nrd, e.nwr);
      end
      total++;
      if (mem[8] !== img[i] || o.wr_addr !== 9'h020) begin
        bad++;
        $display("FAIL rmw%0d_mem got=%h addr=%h want=%h addr=020", i, mem[8], o.wr_addr, img[i]);
      end
    end
  endtask

  task automatic test_load_ext();
    obs_t o;
    exp_t e;
    logic [2:0]  f3 [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000, 3'b000};
    logic [31:0] ad [7] = '{32'h042, 32'h042, 32'h040, 32'h042, 32'h042, 32'h041, 32'h043};
    logic [31:0] ex [7] = '{32'hFFFFFFFF, 32'h000000FF, 32'h00007F01, 32'h000080FF,
                            32'hFFFF80FF, 32'h0000007F, 32'hFFFFFF80};
    preload(9'h040, 32'h80FF7F01);
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{ex[i], 1'b0, 2, 1, 0});
      run_req(1'b0, f3[i], ad[i], 32'h0, o);
      e = sb_q.pop_front();
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd ||
          o.nwr != e.nwr || !o.hold_ok) begin
        bad++;
        $display("FAIL ld%0d rdata=%h err=%b lat=%0d rd=%0d wr=%0d hold=%b want %h %b %0d %0d %0d 1",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, o.hold_ok, e.rdata, e.err, e.lat,
                 e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    exp_t e;
    logic        st [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [7] = '{3'b010, 3'b011, 3'b011, 3'b110, 3'b111, 3'b100, 3'b010};
    logic [31:0] ad [7] = '{32'h200, 32'h010, 32'h010, 32'h010, 32'h010, 32'h010, 32'h400};
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{32'd0, 1'b1, 1, 0, 0});
      run_req(st[i], f3[i], ad[i], 32'h12345678, o);
      e = sb_q.pop_front();
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd ||
          o.nwr != e.nwr || !o.hold_ok) begin
        bad++;
        $display("FAIL ill%0d rdata=%h err=%b lat=%0d rd=%0d wr=%0d hold=%b want %h %b %0d %0d %0d 1",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, o.hold_ok, e.rdata, e.err, e.lat,
                 e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    exp_t e;
    logic [2:0]  f3 [2] = '{3'b010, 3'b001};
    logic [31:0] ad [2] = '{32'h012, 32'h043};
`ifdef LSU_MISALIGN_TRAP_EN
    exp_t ex [2] = '{'{32'd0, 1'b1, 1, 0, 0}, '{32'd0, 1'b1, 1, 0, 0}};
`else
    exp_t ex [2] = '{'{32'hDEADBEEF, 1'b0, 2, 1, 0}, '{32'hFFFF80FF, 1'b0, 2, 1, 0}};
`endif
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(ex[i]);
      run_req(1'b0, f3[i], ad[i], 32'h0, o);
      e = sb_q.pop_front();
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd ||
          o.nwr != e.nwr || !o.hold_ok) begin
        bad++;
        $display("FAIL mis%0d rdata=%h err=%b lat=%0d rd=%0d wr=%0d hold=%b want %h %b %0d %0d %0d 1",
                 i, o.rdata, o.err, o.lat, o.nrd, o.nwr, o.hold_ok, e.rdata, e.err, e.lat,
                 e.nrd, e.nwr);
      end
    end
  endtask

  task automatic test_reset_rmw();
    obs_t o;
    exp_t e;
    int   wr_before;
    preload(9'h030, 32'hCAFEF00D);
    wr_before = wr_cnt;
    @(negedge clk);
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h030;
    bus.req_wdata  = 32'h00001234;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    total++;
    if (bus.MemRead !== 1'b1) begin
      bad++;
      $display("FAIL rst_rmw_rd got=%b want=1", bus.MemRead);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.MemRead, bus.MemWrite, bus.resp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL rst_rmw_drop got=%b want=000", {bus.MemRead, bus.MemWrite, bus.resp_valid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_rmw_ready got=%b want=1", bus.req_ready);
    end
    repeat (3) @(negedge clk);
    total++;
    if (mem[12] !== 32'hCAFEF00D || wr_cnt != wr_before) begin
      bad++;
      $display("FAIL rst_rmw_mem got=%h writes=%0d want=cafef00d writes=%0d", mem[12], wr_cnt,
               wr_before);
    end
    sb_q.push_back('{32'hCAFEF00D, 1'b0, 2, 1, 0});
    run_req(1'b0, 3'b010, 32'h030, 32'h0, o);
    e = sb_q.pop_front();
    total++;
    if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || !o.hold_ok) begin
      bad++;
      $display("FAIL rst_rmw_lw rdata=%h err=%b lat=%0d hold=%b want %h %b %0d 1", o.rdata,
               o.err, o.lat, o.hold_ok, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    // store then immediately load back several distinct words
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'h100 + 32'(i * 4);
      d = $urandom;
      sb_q.push_back('{32'd0, 1'b0, 2, 0, 1});
      sb_q.push_back('{d, 1'b0, 2, 1, 0});
      run_req(1'b1, 3'b010, a, d, o);
      e = sb_q.pop_front();
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nwr != e.nwr ||
          o.wr_data !== d || o.wr_addr !== a[8:0]) begin
        bad++;
        $display("FAIL b2b_sw%0d lat=%0d wr=%0d data=%h addr=%h want lat=2 wr=1 %h %h", i, o.lat,
                 o.nwr, o.wr_data, o.wr_addr, d, a[8:0]);
      end
      run_req(1'b0, 3'b010, a, 32'h0, o);
      e = sb_q.pop_front();
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.nrd != e.nrd) begin
        bad++;
        $display("FAIL b2b_lw%0d rdata=%h lat=%0d rd=%0d want %h 2 1", i, o.rdata, o.lat, o.nrd,
                 e.rdata);
      end
    end
    total++;
    if (both_cnt != 0) begin
      bad++;
      $display("FAIL rd_wr_overlap got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    wr_cnt = 0;
    both_cnt = 0;
    pre_we = 1'b0;
    pre_idx = 7'd0;
    pre_val = 32'd0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    test_reset();
    test_sw_lw();
    test_rmw();
    test_load_ext();
    test_illegal();
    test_misalign();
    test_reset_rmw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1: core presents an access.
REQ-004 SHALL have port req_ready, output, 1: unit accepts an access this cycle.
REQ-005 SHALL have port req_store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3: RV32I size/sign code.
REQ-007 SHALL have port req_addr, input, 32: byte address.
REQ-008 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-009 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32: extended load result; 0 for stores and errors.
REQ-011 SHALL have port resp_err, output, 1: access rejected; valid only with resp_valid.
REQ-012 SHALL have port MemRead, output, 1: data-memory read enable.
REQ-013 SHALL have port MemWrite, output, 1: data-memory write enable.
REQ-014 SHALL have port mem_addr, output, 9: data-memory byte address; bits [1:0] always 0.
REQ-015 SHALL have port mem_wdata, output, 32: data-memory write word.
REQ-016 SHALL have port mem_rdata, input, 32: combinational data-memory read word.

Function
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; req_ready=1 only in IDLE.
REQ-018 SHALL register req_store, req_funct3, req_addr, req_wdata at acceptance; later input changes SHALL NOT affect the transaction.
REQ-019 SHALL implement states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-020 SHALL, for a valid load, go IDLE->LOAD->RESP: MemRead=1 during LOAD, mem_rdata captured at LOAD end, resp_valid 2 cycles after acceptance.
REQ-021 SHALL, for SW, go IDLE->WRITE->RESP: MemWrite=1 during WRITE with mem_wdata=req_wdata.
REQ-022 SHALL, for SB/SH, go IDLE->RMW_RD->WRITE->RESP: read the word, replace only the addressed byte/halfword lanes, write the merged word; resp_valid 3 cycles after acceptance.
REQ-023 SHALL select lanes by addr[1:0]: byte lane = addr[1:0]; halfword lane = addr[1].
REQ-024 SHALL sign-extend LB (000) and LH (001), zero-extend LBU (100) and LHU (101), pass LW (010) unchanged.
REQ-025 SHALL treat load funct3 011/110/111 and store funct3 other than 000/001/010 as illegal: IDLE->RESP, resp_err=1, no memory strobe.
REQ-026 SHALL treat req_addr[31:9] != 0 as out of range, handled as REQ-025.
REQ-027 SHALL drive mem_addr = {captured addr[8:2], 2'b00}; mem_addr and mem_wdata SHALL be stable for the whole cycle in which MemWrite=1.
REQ-028 SHALL never assert MemRead and MemWrite together; both SHALL be 0 outside LOAD, RMW_RD, WRITE.
REQ-029 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-030 SHALL hold resp_rdata and resp_err until the next resp_valid.

Reset
REQ-031 SHALL, on rst_n=0, immediately force state IDLE, MemRead=0, MemWrite=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0.
REQ-032 SHALL abandon any in-flight transaction on reset; a partially complete RMW SHALL NOT write memory; req_ready=1 on the first edge after rst_n rises.

Configuration
REQ-033 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 as illegal per REQ-025.
REQ-034 SHALL, without LSU_MISALIGN_TRAP_EN, clear the offending low address bits (natural alignment) and complete the access normally.

Verification
REQ-035 SHALL cover: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> one MemWrite pulse at mem_addr 0x010; load resp_rdata 0xDEADBEEF 2 cycles after acceptance.
REQ-036 SHALL cover: word 0x11223344 at 0x020, SB 0x023 data 0x000000AA -> MemRead then MemWrite, memory 0xAA223344; resp_valid 3 cycles after acceptance.
REQ-037 SHALL cover: word 0x80FF7F01 at 0x040, LB 0x042 -> 0xFFFFFFFF; LBU 0x042 -> 0x000000FF; LH 0x040 -> 0x00007F01; LHU 0x042 -> 0x000080FF.
REQ-038 SHALL cover: LW 0x200 (out of range) and store funct3 011 -> resp_err=1 one cycle after acceptance, no MemRead/MemWrite.
REQ-039 SHALL cover: LW 0x012 -> with macro resp_err=1; without, reads word at 0x010.
REQ-040 SHALL cover: rst_n low during RMW_RD of SH 0x030 -> strobes drop immediately, memory at 0x030 unchanged, req_ready=1 after release.
